// File: rtl/conv_pkg.sv
// Definitions shared by the RAM readback engine and the PCIe-to-RAM loader:
// default bus widths, the transfer state encoding and a buffer sizing helper.
package conv_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bits needed to hold an occupancy value from 0 up to depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/readback_fifo.sv
// Small synchronous FIFO. The head word is presented combinationally and reads
// as zero while the FIFO is empty.
module readback_fifo
  import conv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // Pointer advance that wraps correctly for depths that are not powers of two.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ram_readback.sv
// Streams a block of RAM port-B words, in address order, into a ready/valid
// output, throttling reads so the small output buffer can never overflow.
module ram_readback
  import conv_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_width(BUF_DEPTH);
  localparam int OCC_W = CNT_W + 1;

  logic [1:0]        rst_sync;
  logic              rst_n;
  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W:0]   issue_left;
  logic [ADDR_W:0]   xfer_left;
  logic              vld_p1;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  lim;

  // Assertion passes straight through; release is retimed by two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // A read may issue only if its word is guaranteed a buffer slot on arrival.
  assign pop   = out_valid && out_ready;
  assign occ   = OCC_W'(fifo_count) + OCC_W'(vld_p1);
  assign lim   = OCC_W'(BUF_DEPTH) + OCC_W'(pop);
  assign enb   = (state == ST_READ) && (occ < lim) && !(fifo_full && !pop);
  assign addrb = enb ? cur_addr : last_addr;
  assign busy  = (state == ST_READ) || (state == ST_DRAIN);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_addr   <= '0;
      last_addr  <= '0;
      issue_left <= '0;
      xfer_left  <= '0;
      vld_p1     <= 1'b0;
    end else begin
      // p1: doutb carries the word for the read issued last cycle
      vld_p1 <= enb;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length != '0) begin
              cur_addr   <= base_addr;
              issue_left <= length;
              xfer_left  <= length;
              state      <= ST_READ;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_READ: begin
          if (enb) begin
            last_addr  <= cur_addr;
            cur_addr   <= cur_addr + ADDR_W'(1);
            issue_left <= issue_left - (ADDR_W+1)'(1);
            if (issue_left == (ADDR_W+1)'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: ;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
      if (pop) begin
        xfer_left <= xfer_left - (ADDR_W+1)'(1);
        if (state == ST_DRAIN && xfer_left == (ADDR_W+1)'(1)) state <= ST_DONE;
      end
    end
  end

  readback_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst_n),
    .wr_en   (vld_p1),
    .wr_data (doutb),
    .rd_en   (pop),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_ram_readback.sv
// Bench for ram_readback: a keyed RAM model on port B, a monitor logging
// issued reads and delivered words, and one task per scenario.
module tb_ram_readback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [16:0] length = '0;
  logic        enb;
  logic [15:0] addrb;
  logic [15:0] doutb = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  logic [15:0] key = '0;

  logic [15:0] iss_q[$];
  int          iss_t[$];
  logic [15:0] got_q[$];
  int          got_t[$];
  int cyc = 0, done_cnt = 0, done_t = 0, busy_cnt = 0, ov_cnt = 0;
  int ovf_cnt = 0, stall_err = 0, pend = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  ram_readback #(.ADDR_W(16), .DATA_W(16), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .enb(enb), .addrb(addrb), .doutb(doutb), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ram_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ key;
  endfunction

  // RAM: data one cycle after enb, noise otherwise.
  always @(posedge clk) begin
    if (enb) doutb <= ram_word(addrb);
    else     doutb <= 16'($urandom);
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      pend = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
      if (enb) begin iss_q.push_back(addrb); iss_t.push_back(cyc); end
      if (out_valid && out_ready) begin got_q.push_back(out_data); got_t.push_back(cyc); end
      pend = pend + int'(enb) - int'(out_valid && out_ready);
      if (pend > DEPTH) ovf_cnt++;
      if (done) begin done_cnt++; done_t = cyc; end
      if (busy) busy_cnt++;
      if (out_valid) ov_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic launch(input logic [15:0] b, input logic [16:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output logic ok);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin step(); n++; end
    ok = (done_cnt != d0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++; if (enb !== 1'b0)       begin errors++; $display("FAIL rst_enb: got %b want 0", enb); end
    checks++; if (addrb !== 16'h0)    begin errors++; $display("FAIL rst_addrb: got %h want 0000", addrb); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0000", out_data); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    repeat (3) step();
    rst = 1'b1;
    repeat (4) step();
    checks++; if (busy !== 1'b0 || enb !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got busy=%b enb=%b want 0 0", busy, enb); end
  endtask

  task automatic test_basic();
    int i0, g0, d0;
    logic ok;
    ready_mode = 0;
    i0 = iss_q.size(); g0 = got_q.size(); d0 = done_cnt;
    launch(16'h0010, 17'd4);
    wait_done(d0, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: got no done want pulse"); end
    step(); step();
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL basic_done_once: got %0d pulses want 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    checks++; if (iss_q.size() - i0 != 4 || got_q.size() - g0 != 4) begin
      errors++; $display("FAIL basic_counts: got %0d reads %0d words want 4 4", iss_q.size() - i0, got_q.size() - g0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (iss_q[i0+k] !== 16'(16'h10 + k)) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", k, iss_q[i0+k], 16'(16'h10 + k)); end
        checks++; if (iss_t[i0+k] != iss_t[i0] + k) begin errors++; $display("FAIL basic_addr_cycle%0d: got +%0d want +%0d", k, iss_t[i0+k] - iss_t[i0], k); end
        checks++; if (got_q[g0+k] !== ram_word(16'(16'h10 + k))) begin errors++; $display("FAIL basic_word%0d: got %h want %h", k, got_q[g0+k], ram_word(16'(16'h10 + k))); end
      end
      checks++; if (got_t[g0] != iss_t[i0] + 2) begin errors++; $display("FAIL basic_first_latency: got %0d want 2", got_t[g0] - iss_t[i0]); end
      checks++; if (done_t != got_t[g0+3] + 1) begin errors++; $display("FAIL basic_done_timing: got %0d want 1", done_t - got_t[g0+3]); end
    end
  endtask

  task automatic test_wrap();
    int i0, g0, d0;
    logic ok;
    ready_mode = 0;
    i0 = iss_q.size(); g0 = got_q.size(); d0 = done_cnt;
    launch(16'hFFFE, 17'd4);
    wait_done(d0, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done: got no done want pulse"); end
    step();
    checks++; if (iss_q.size() - i0 != 4 || got_q.size() - g0 != 4) begin
      errors++; $display("FAIL wrap_counts: got %0d reads %0d words want 4 4", iss_q.size() - i0, got_q.size() - g0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (iss_q[i0+k] !== 16'(32'hFFFE + k)) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", k, iss_q[i0+k], 16'(32'hFFFE + k)); end
        checks++; if (got_q[g0+k] !== ram_word(16'(32'hFFFE + k))) begin errors++; $display("FAIL wrap_word%0d: got %h want %h", k, got_q[g0+k], ram_word(16'(32'hFFFE + k))); end
      end
    end
  endtask

  task automatic test_stall();
    int i0, g0, d0, s0, o0, bad;
    logic ok;
    logic [15:0] b;
    b = 16'($urandom);
    ready_mode = 1;
    i0 = iss_q.size(); g0 = got_q.size(); d0 = done_cnt; s0 = stall_err; o0 = ovf_cnt;
    launch(b, 17'd8);
    wait_done(d0, 120, ok);
    ready_mode = 0;
    step();
    checks++; if (!ok) begin errors++; $display("FAIL stall_done: got no done want pulse"); end
    checks++; if (got_q.size() - g0 != 8) begin errors++; $display("FAIL stall_count: got %0d words want 8", got_q.size() - g0); end
    bad = 0;
    for (int k = 0; k < 8 && g0 + k < got_q.size(); k++)
      if (got_q[g0+k] !== ram_word(16'(b + k))) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_words: got %0d wrong words want 0", bad); end
    checks++; if (stall_err != s0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_err - s0); end
    checks++; if (ovf_cnt != o0) begin errors++; $display("FAIL stall_overflow: got %0d over-issue cycles want 0", ovf_cnt - o0); end
    checks++; if (iss_q.size() - i0 != 8) begin errors++; $display("FAIL stall_reads: got %0d reads want 8", iss_q.size() - i0); end
  endtask

  task automatic test_zero_len();
    int i0, d0, b0, v0;
    logic ok;
    ready_mode = 0;
    i0 = iss_q.size(); d0 = done_cnt; b0 = busy_cnt; v0 = ov_cnt;
    launch(16'h1234, 17'd0);
    wait_done(d0, 10, ok);
    repeat (4) step();
    checks++; if (!ok || done_cnt != d0 + 1) begin errors++; $display("FAIL zero_done: got %0d pulses want 1", done_cnt - d0); end
    checks++; if (iss_q.size() != i0) begin errors++; $display("FAIL zero_reads: got %0d want 0", iss_q.size() - i0); end
    checks++; if (ov_cnt != v0) begin errors++; $display("FAIL zero_valid: got %0d valid cycles want 0", ov_cnt - v0); end
    checks++; if (busy_cnt != b0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_cnt - b0); end
  endtask

  task automatic test_ignore_start();
    int i0, g0, d0, bad;
    logic ok;
    logic [15:0] b;
    b = 16'h0A00 + 16'($urandom_range(0, 255));
    ready_mode = 1;
    i0 = iss_q.size(); g0 = got_q.size(); d0 = done_cnt;
    launch(b, 17'd6);
    step(); step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", busy); end
    launch(16'h0100, 17'd3);
    wait_done(d0, 120, ok);
    ready_mode = 0;
    repeat (10) step();
    checks++; if (!ok || done_cnt != d0 + 1) begin errors++; $display("FAIL ign_done: got %0d pulses want 1", done_cnt - d0); end
    checks++; if (iss_q.size() - i0 != 6 || got_q.size() - g0 != 6) begin
      errors++; $display("FAIL ign_counts: got %0d reads %0d words want 6 6", iss_q.size() - i0, got_q.size() - g0);
    end else begin
      bad = 0;
      for (int k = 0; k < 6; k++)
        if (iss_q[i0+k] !== 16'(b + k) || got_q[g0+k] !== ram_word(16'(b + k))) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL ign_sequence: got %0d wrong entries want 0", bad); end
    end
  endtask

  task automatic test_reset_mid();
    int g0, d0, n, i1, g1;
    logic ok;
    ready_mode = 0;
    g0 = got_q.size(); d0 = done_cnt;
    launch(16'h0300, 17'd8);
    n = 0;
    while (got_q.size() < g0 + 3 && n < 40) begin step(); n++; end
    checks++; if (got_q.size() < g0 + 3) begin errors++; $display("FAIL mid_third_word: got %0d words want 3", got_q.size() - g0); end
    rst = 1'b0;
    #1;
    checks++; if ({enb, addrb, out_valid, out_data, busy, done} !== 35'h0) begin
      errors++; $display("FAIL mid_rst_outputs: got enb=%b addrb=%h ov=%b od=%h busy=%b done=%b want all 0", enb, addrb, out_valid, out_data, busy, done);
    end
    repeat (3) step();
    rst = 1'b1;
    repeat (5) step();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt - d0); end
    i1 = iss_q.size(); g1 = got_q.size();
    launch(16'h0020, 17'd2);
    wait_done(d0, 40, ok);
    repeat (3) step();
    checks++; if (!ok) begin errors++; $display("FAIL mid_restart_done: got no done want pulse"); end
    checks++; if (got_q.size() - g1 != 2 || iss_q.size() - i1 != 2) begin
      errors++; $display("FAIL mid_restart_counts: got %0d words %0d reads want 2 2", got_q.size() - g1, iss_q.size() - i1);
    end else begin
      checks++; if (got_q[g1] !== ram_word(16'h0020) || got_q[g1+1] !== ram_word(16'h0021)) begin
        errors++; $display("FAIL mid_restart_words: got %h %h want %h %h", got_q[g1], got_q[g1+1], ram_word(16'h0020), ram_word(16'h0021));
      end
    end
  endtask

  task automatic test_random();
    int i0, g0, d0, o0, len, bad;
    logic ok;
    logic [15:0] b;
    for (int t = 0; t < 6; t++) begin
      b   = (t % 2 == 0) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15));
      len = $urandom_range(1, 20);
      ready_mode = 2;
      i0 = iss_q.size(); g0 = got_q.size(); d0 = done_cnt; o0 = ovf_cnt;
      launch(b, 17'(len));
      wait_done(d0, len * 8 + 40, ok);
      ready_mode = 0;
      step();
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_done: got no done want pulse", t); end
      bad = 0;
      if (got_q.size() - g0 != len || iss_q.size() - i0 != len) bad = len + 1;
      else
        for (int k = 0; k < len; k++)
          if (iss_q[i0+k] !== 16'(b + k) || got_q[g0+k] !== ram_word(16'(b + k))) bad++;
      checks++; if (bad != 0 || ovf_cnt != o0) begin
        errors++; $display("FAIL rnd%0d_stream: got %0d bad entries %0d overflows want 0 0 (base %h len %0d)", t, bad, ovf_cnt - o0, b, len);
      end
    end
  endtask

  initial begin
    key = 16'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_len();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
